request_queue: RTL and testbench
================================

Name: request_queue

Overview:
- Consumer end of the parser output interface: accepts parsed memory operations (opcode, address) on op_ready_s and buffers them in an in-order queue for the DRAM command scheduler.
- Returns backpressure (q_full) to the parser.
- Tracks the age of every entry in clock cycles, so the scheduler can enforce timing and report latency.
- Sits between parser and the DRAM scheduler in the memory controller top level.

Parameters:
ADDRESS_WIDTH, 32, width of address field (matches parser)
DEPTH, 16, number of queue entries (power of 2)
AGE_WIDTH, 8, width of per-entry age counter (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
op_ready_s  input  1  parser strobe: opcode/address valid this cycle
opcode  input  parsed_op_t  operation type from parser
address  input  ADDRESS_WIDTH  byte address from parser
q_full  output  1  queue cannot accept a push this cycle (to parser)
head_valid  output  1  queue non-empty, head fields valid
head_opcode  output  parsed_op_t  opcode of oldest entry
head_address  output  ADDRESS_WIDTH  address of oldest entry
head_age  output  AGE_WIDTH  cycles since oldest entry was enqueued
pop  input  1  scheduler retires the head entry
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: a push was dropped

Behaviour:
- Reset (async, rst_n low): rd_ptr=wr_ptr=0, count=0, overflow=0; outputs head_valid=0, q_full=0, head_age=0, head_opcode=0, head_address=0. Entry storage need not clear. Deassertion mid-operation discards all queued ops.
- pop_ok = pop && head_valid. A pop while empty is ignored, with no pointer change.
- push_ok = op_ready_s && (count<DEPTH || pop_ok). Push and pop in the same cycle while full is legal; count stays DEPTH.
- q_full = (count==DEPTH), combinational from the registered count.
- Push writes {opcode, address, age=0} at wr_ptr. wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Pop increments rd_ptr modulo DEPTH.
- count updates: +1 on push only, -1 on pop only, unchanged on both.
- op_ready_s && !push_ok: entry dropped, overflow set to 1 and held until reset.
- Latency: a push in cycle N makes head_valid visible in cycle N+1 when previously empty. There is no same-cycle bypass.
- Head outputs are combinational reads of the entry at rd_ptr. They are zero when empty.
- Age: every occupied entry's age increments by 1 each cycle and saturates at 2^AGE_WIDTH-1. An entry pushed in cycle N shows age 0 in N+1 and age 1 in N+2.
- opcode is stored verbatim; no decoding or validation is done in this block.
- State (occupancy view):
  - EMPTY (count=0): push -> PARTIAL.
  - PARTIAL: push only with count=DEPTH-1 -> FULL; pop only with count=1 -> EMPTY.
  - FULL: pop -> PARTIAL; push+pop -> FULL.

Decomposition:
- global_defs gains:
  - QUEUE_DEPTH=16 constant
  - queue_entry_t packed struct {parsed_op_t opcode; logic [31:0] address; logic [7:0] age;}
- parsed_op_t is reused unchanged.
- One natural sub-module: sat_counter, a saturating age incrementer with clear, instantiated per entry via generate.

Test Plan:
1. Reset then single push of opcode=0, address=32'h0000_1A40 at cycle 2 -> head_valid=1 in cycle 3, head_address=32'h1A40, count=1, head_age increments 0,1,2 per cycle.
2. 16 back-to-back pushes with addresses 0x0..0xF, no pop -> q_full=1 after the 16th push; a 17th push is dropped and sets overflow=1, count stays 16.
3. Full queue, simultaneous op_ready_s (address 0x100) and pop:
   - head becomes entry 0x1, count=16, overflow unchanged.
   - after 15 further pops, head_address=0x100 (wrap-around of wr_ptr verified).
4. pop asserted while empty -> no change: count=0, pointers unchanged, head_valid=0.
5. AGE_WIDTH=8, hold one entry 300 cycles -> head_age saturates at 255 and stays.
6. rst_n pulled low asynchronously mid-cycle with 5 entries queued -> immediately count=0, head_valid=0, q_full=0, overflow=0; the next push has age 0.

Source files
------------

// File: rtl/request_queue_pkg.sv
// Shared types for the parser-to-scheduler request queue: opcode encoding,
// queue entry layout and the occupancy state exported for debug.
package request_queue_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_ACTIVATE = 2'd2,
        OP_REFRESH  = 2'd3
    } parsed_op_t;

    localparam int QUEUE_DEPTH = 16;

    typedef struct packed {
        parsed_op_t  opcode;
        logic [31:0] address;
        logic [7:0]  age;
    } queue_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/request_queue_sat_counter.sv
// Per-entry age counter: clears when the slot is written, counts while the
// slot is occupied and sticks at all-ones.
module request_queue_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (en && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/request_queue.sv
// In-order request queue between the parser and the DRAM scheduler, with
// backpressure, sticky drop flag and a saturating age per entry.
//
// Handshake: the parser strobe op_ready_s is a push attempt; it is accepted
// when the queue is not full or the head is retired in the same cycle, and is
// otherwise dropped and recorded in overflow. pop retires the head only when
// head_valid is high; a pop on an empty queue has no effect.
module request_queue
    import request_queue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = QUEUE_DEPTH,
    parameter int AGE_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_ready_s,
    input  parsed_op_t               opcode,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     q_full,
    output logic                     head_valid,
    output parsed_op_t               head_opcode,
    output logic [ADDRESS_WIDTH-1:0] head_address,
    output logic [AGE_WIDTH-1:0]     head_age,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output occ_state_t               occ_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic                     push_ok;
    logic                     pop_ok;
    parsed_op_t               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [AGE_WIDTH-1:0]     age_mem  [DEPTH];
    logic [DEPTH-1:0]         occupied;
    occ_state_t               state_q;
    occ_state_t               state_d;

    assign head_valid = (count != '0);
    assign q_full     = (count == FULL_COUNT);
    assign pop_ok     = pop && head_valid;
    assign push_ok    = op_ready_s && (!q_full || pop_ok);
    assign occ_state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state_q  <= OCC_EMPTY;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (op_ready_s && !push_ok) begin
                overflow <= 1'b1;
            end
            state_q <= state_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            op_mem[wr_ptr]   <= opcode;
            addr_mem[wr_ptr] <= address;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] rel;
        rel      = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel         = PW'(i) - rd_ptr;
            occupied[i] = ({1'b0, rel} < count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        request_queue_sat_counter #(
            .W(AGE_WIDTH)
        ) u_age (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(push_ok && (wr_ptr == PW'(g))),
            .en   (occupied[g]),
            .value(age_mem[g])
        );
    end

    always_comb begin
        head_opcode  = OP_READ;
        head_address = '0;
        head_age     = '0;
        if (head_valid) begin
            head_opcode  = op_mem[rd_ptr];
            head_address = addr_mem[rd_ptr];
            head_age     = age_mem[rd_ptr];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push_ok) begin
                    state_d = OCC_PARTIAL;
                end
            end
            OCC_PARTIAL: begin
                if (push_ok && !pop_ok && (count == LAST_COUNT)) begin
                    state_d = OCC_FULL;
                end else if (pop_ok && !push_ok && (count == ONE_COUNT)) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop_ok && !push_ok) begin
                    state_d = OCC_PARTIAL;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_request_queue.sv
// Scoreboard bench for request_queue: directed scenarios followed by biased
// random traffic, checked each cycle against a queue-based reference model.
module tb_request_queue;
    import request_queue_pkg::*;

    localparam int AW      = 32;
    localparam int DEPTH   = 16;
    localparam int AGEW    = 8;
    localparam int CW      = 5;
    localparam int EW      = 2 + AW + 32;
    localparam int AGE_MAX = 255;

    logic             clk;
    logic             rst_n;
    logic             op_ready_s;
    parsed_op_t       opcode;
    logic [AW-1:0]    address;
    logic             q_full;
    logic             head_valid;
    parsed_op_t       head_opcode;
    logic [AW-1:0]    head_address;
    logic [AGEW-1:0]  head_age;
    logic             pop;
    logic [CW-1:0]    count;
    logic             overflow;
    occ_state_t       occ_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int m_count  = 0;
    bit m_ovf    = 0;
    bit run_mon  = 0;

    // Each expected entry: {opcode, address, cycle it was issued in}.
    logic [EW-1:0] exp_q[$];

    request_queue #(
        .ADDRESS_WIDTH(AW),
        .DEPTH        (DEPTH),
        .AGE_WIDTH    (AGEW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_ready_s  (op_ready_s),
        .opcode      (opcode),
        .address     (address),
        .q_full      (q_full),
        .head_valid  (head_valid),
        .head_opcode (head_opcode),
        .head_address(head_address),
        .head_age    (head_age),
        .pop         (pop),
        .count       (count),
        .overflow    (overflow),
        .occ_state   (occ_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the rising edge and are sampled at the
    // next one; the model commits after the monitor has looked at this cycle.
    task automatic drive(input bit v, input logic [1:0] op, input logic [AW-1:0] a, input bit p);
        bit pop_ok;
        bit push_ok;
        @(posedge clk);
        #1;
        op_ready_s = v;
        opcode     = parsed_op_t'(op);
        address    = a;
        pop        = p;
        pop_ok     = p && (m_count > 0);
        push_ok    = v && ((m_count < DEPTH) || pop_ok);
        if (push_ok) exp_q.push_back({op, a, 32'(cyc)});
        @(negedge clk);
        #1;
        m_count = m_count + int'(push_ok) - int'(pop_ok);
        if (v && !push_ok) m_ovf = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        op_ready_s = 1'b0;
        pop        = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_head_valid", head_valid, 0);
        chk("rst_q_full", q_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_head_age", head_age, 0);
        chk("rst_head_address", head_address, 0);
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [EW-1:0] e;
        int            exp_age;
        occ_state_t    exp_state;
        if (run_mon && rst_n) begin
            exp_state = (m_count == 0) ? OCC_EMPTY : (m_count == DEPTH) ? OCC_FULL : OCC_PARTIAL;
            chk("count", count, m_count);
            chk("q_full", q_full, m_count == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("head_valid", head_valid, m_count > 0);
            chk("occ_state", occ_state, exp_state);
            if (m_count > 0) begin
                e       = exp_q[0];
                exp_age = cyc - int'(e[31:0]) - 1;
                if (exp_age > AGE_MAX) exp_age = AGE_MAX;
                chk("head_opcode", head_opcode, e[EW-1:EW-2]);
                chk("head_address", head_address, e[63:32]);
                chk("head_age", head_age, exp_age);
                if (pop) void'(exp_q.pop_front());
            end else begin
                chk("empty_head_opcode", head_opcode, 0);
                chk("empty_head_address", head_address, 0);
                chk("empty_head_age", head_age, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        op_ready_s = 1'b0;
        opcode     = OP_READ;
        address    = '0;
        pop        = 1'b0;
        rst_n      = 1'b0;
        #22;
        chk("init_count", count, 0);
        chk("init_head_valid", head_valid, 0);
        chk("init_q_full", q_full, 0);
        chk("init_overflow", overflow, 0);
        chk("init_head_age", head_age, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        run_mon = 1'b1;

        // single push, then watch the age climb
        idle(1);
        drive(1'b1, 2'd0, 32'h0000_1A40, 1'b0);
        idle(4);
        drive(1'b0, 2'd0, '0, 1'b1);
        idle(1);

        // fill to 16, drop a 17th
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 2'($urandom_range(0, 3)), 32'(i), 1'b0);
        drive(1'b1, 2'd1, 32'h0000_0200, 1'b0);
        idle(1);

        // push+pop while full, then drain to the wrapped entry
        drive(1'b1, 2'd2, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b0, 2'd0, '0, 1'b1);
        idle(1);
        drive(1'b0, 2'd0, '0, 1'b1);

        // pops while empty are ignored
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, '0, 1'b1);
        drive(1'b1, 2'd3, 32'hCAFE_0004, 1'b0);
        drive(1'b0, 2'd0, '0, 1'b1);

        // hold one entry long enough to saturate its age
        drive(1'b1, 2'd1, 32'h0000_5000, 1'b0);
        idle(300);
        drive(1'b0, 2'd0, '0, 1'b1);

        // reset mid-operation with 5 entries queued
        for (int i = 0; i < 5; i++) drive(1'b1, 2'($urandom_range(0, 3)), $urandom(), 1'b0);
        async_reset();
        drive(1'b1, 2'd2, 32'h0000_7770, 1'b0);
        idle(2);
        drive(1'b0, 2'd0, '0, 1'b1);

        // biased random phases, each starting from a clean reset
        for (int ph = 0; ph < 4; ph++) begin
            int push_pct;
            int pop_pct;
            push_pct = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
            pop_pct  = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 50 : 85;
            async_reset();
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 99) < push_pct, 2'($urandom_range(0, 3)), $urandom(),
                      $urandom_range(0, 99) < pop_pct);
            end
        end
        idle(2);

        run_mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
